gold_code_gen: RTL and testbench
================================

GOLD_CODE_GEN -- requirements
Module: gold_code_gen

Interface
REQ-001 SHALL have parameter N, default 10: LFSR length in bits.
REQ-002 SHALL have parameter CODE_LEN, default 1023: chips per code epoch, 2..2^N-1.
REQ-003 SHALL have parameter G1_MASK, default 10'b10_0000_0100: G1 feedback taps, stages 10 and 3.
REQ-004 SHALL have parameter G2_MASK, default 10'b11_1010_0110: G2 feedback taps, stages 10, 9, 8, 6, 3 and 2.
REQ-005 SHALL have parameter PW, default $clog2(CODE_LEN): width of phase and slew counts.
REQ-006 SHALL have ports, in this order, each given as name, direction, width, meaning:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-low.
- chip_en  in  1  one-cycle chip-rate strobe.
- load  in  1  pulse; captures the init and tap inputs.
- g1_init  in  N  G1 seed.
- g2_init  in  N  G2 seed.
- t0  in  4  G2 tap select; 0 selects G2-init mode.
- t1  in  4  second G2 tap select.
- slew_req  in  1  pulse; starts a slew.
- slew_dir  in  1  1 advances the code, 0 retards it.
- slew_cnt  in  PW  slew size in chips.
- slew_busy  out  1  a slew is in progress.
- chip_e  out  1  early chip.
- chip_p  out  1  prompt chip.
- chip_l  out  1  late chip.
- epoch  out  1  one-cycle pulse at code wrap.
- phase  out  PW  chip index of the early chip.

Function
REQ-007 A "step" SHALL shift both LFSRs by one stage: stage[1] takes the XOR of the masked stages, and stage[k] takes stage[k-1].
REQ-008 Raw chip SHALL be g1[N]^g2[t0]^g2[t1]; when the registered t0 is 0, raw chip SHALL be g1[N]^g2[N].
REQ-009 chip_e SHALL be the raw chip; chip_p SHALL be chip_e delayed one step; chip_l SHALL be chip_p delayed one step.
REQ-010 On each step, phase SHALL increment.
REQ-011 A step taken at phase==CODE_LEN-1 SHALL set phase to 0 and reload both LFSRs from the seed registers.
REQ-012 A step taken at phase==CODE_LEN-1 SHALL assert epoch for exactly that following cycle.
REQ-013 load SHALL register g1_init, g2_init, t0 and t1 on the same edge.
REQ-014 load SHALL seed both LFSRs, set phase to 0 and clear the delay line.
REQ-015 load SHALL abort any slew to IDLE, and SHALL NOT assert epoch.
REQ-016 load SHALL take priority over chip_en and slew_req in the same cycle.
REQ-017 The slew FSM SHALL have the states IDLE, RETARD and ADVANCE.
- In IDLE, a step SHALL occur when chip_en is high.
- In IDLE, slew_req with slew_cnt>0 SHALL go to RETARD or ADVANCE per slew_dir and load the remaining count.
- slew_req with slew_cnt==0 SHALL be a no-op.
REQ-018 In RETARD, steps SHALL be suppressed; each chip_en SHALL decrement the remaining count, and the FSM SHALL return to IDLE when it reaches 0.
REQ-019 In ADVANCE, a step SHALL occur every clk cycle; the remaining count SHALL decrement only on cycles without chip_en, and the FSM SHALL go to IDLE at 0.
REQ-020 slew_req while slew_busy is high SHALL be ignored.
REQ-021 slew_busy SHALL be high in RETARD and ADVANCE only.
REQ-022 Epoch wrap (REQ-011) SHALL operate normally during slews.
REQ-023 Outputs SHALL be registered, with zero added latency from a step to chip_e, phase and epoch.

Reset
REQ-024 rst low SHALL set, asynchronously:
- g1 and g2 to all ones;
- t0=2 and t1=6 (PRN 1);
- seed registers to all ones;
- phase=0 and delay line 0;
- chip_p=0, chip_l=0, epoch=0, slew_busy=0 and FSM IDLE.
REQ-025 Reset asserted mid-slew SHALL abandon the slew with no residual count.
REQ-026 After release, the first step SHALL occur on the first chip_en.

Structure
REQ-027 Package gnss_pkg SHALL hold the slew state enum, the GPS default masks and CODE_LEN_CA=1023.
REQ-028 Sub-module lfsr_step SHALL implement one masked LFSR with seed load and step enable; it SHALL be instantiated twice.

Verification
REQ-029 Reset, then 10 chip_en: chip_e sequence SHALL be 1,1,0,0,1,0,0,0,0,0 (PRN 1, octal 1440).
REQ-030 1023 consecutive chip_en: epoch SHALL pulse once, phase SHALL read 0, and the next 10 chips SHALL repeat REQ-029.
REQ-031 Retard with slew_cnt=5: over 20 chip_en the code SHALL lag a free-running model by exactly 5 chips, and slew_busy SHALL be high for those 5 chip_en.
REQ-032 Advance with slew_cnt=3 and chip_en every 4th clk: the code SHALL lead the model by exactly 3 chips; chip_p and chip_l SHALL trail chip_e by 1 and 2 steps.
REQ-033 load with t0=0 at phase 500 during an ADVANCE: slew_busy SHALL go 0, phase SHALL be 0 and chip_e SHALL equal g1[N]^g2[N].
REQ-034 CODE_LEN=7, N=3: epoch SHALL pulse every 7 chip_en.

Source files
------------

// File: rtl/gnss_pkg.sv
// Shared GNSS code-generator types and GPS C/A defaults.
package gnss_pkg;

   typedef enum logic [1:0] {
      SLEW_IDLE,
      SLEW_RETARD,
      SLEW_ADVANCE
   } slew_state_t;

   localparam int unsigned CODE_LEN_CA = 1023;
   localparam logic [9:0]  G1_MASK_CA  = 10'b10_0000_0100;
   localparam logic [9:0]  G2_MASK_CA  = 10'b11_1010_0110;
   localparam logic [3:0]  T0_PRN1     = 4'd2;
   localparam logic [3:0]  T1_PRN1     = 4'd6;

endpackage

// File: rtl/lfsr_step.sv
// One masked Fibonacci LFSR; bit i holds stage i+1, stage 1 takes the feedback.
module lfsr_step
   import gnss_pkg::*;
#(
   parameter int             N    = 10,
   parameter logic [N-1:0]   MASK = G1_MASK_CA
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic         ld,
   input  logic         en,
   input  logic [N-1:0] seed,
   output logic [N-1:0] q_nxt
);

   logic [N-1:0] q;

   always_comb begin
      q_nxt = q;
      if (ld)
         q_nxt = seed;
      else if (en)
         q_nxt = {q[N-2:0], ^(q & MASK)};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         q <= '1;
      else
         q <= q_nxt;
   end

endmodule

// File: rtl/gold_code_gen.sv
// Gold code generator with early/prompt/late taps, epoch tracking and chip slewing.
module gold_code_gen
   import gnss_pkg::*;
#(
   parameter int           N        = 10,
   parameter int           CODE_LEN = CODE_LEN_CA,
   parameter logic [N-1:0] G1_MASK  = G1_MASK_CA,
   parameter logic [N-1:0] G2_MASK  = G2_MASK_CA,
   parameter int           PW       = $clog2(CODE_LEN)
)
(
   input  logic          clk,
   input  logic          rst,
   input  logic          chip_en,
   input  logic          load,
   input  logic [N-1:0]  g1_init,
   input  logic [N-1:0]  g2_init,
   input  logic [3:0]    t0,
   input  logic [3:0]    t1,
   input  logic          slew_req,
   input  logic          slew_dir,
   input  logic [PW-1:0] slew_cnt,
   output logic          slew_busy,
   output logic          chip_e,
   output logic          chip_p,
   output logic          chip_l,
   output logic          epoch,
   output logic [PW-1:0] phase
);

   localparam logic [PW-1:0] LAST = PW'(CODE_LEN - 1);

   slew_state_t   state;
   logic [PW-1:0] rem;
   logic [N-1:0]  g1_seed, g2_seed;
   logic [N-1:0]  g1_src, g2_src;
   logic [N-1:0]  g1_nxt, g2_nxt;
   logic [3:0]    t0_r, t1_r, t0_nxt, t1_nxt;
   logic          step, wrap, reseed;

   // Tap selects are 1-based stage numbers; out-of-range selects contribute 0.
   function automatic logic raw_chip(input logic [N-1:0] g1, input logic [N-1:0] g2,
                                     input logic [3:0] ta, input logic [3:0] tb);
      logic sa, sb;
      sa = 1'b0;
      sb = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (ta == 4'(i + 1)) sa = g2[i];
         if (tb == 4'(i + 1)) sb = g2[i];
      end
      return (ta == 4'd0) ? (g1[N-1] ^ g2[N-1]) : (g1[N-1] ^ sa ^ sb);
   endfunction

   always_comb begin
      step = 1'b0;
      if (!load) begin
         case (state)
            SLEW_IDLE:    step = chip_en;
            SLEW_ADVANCE: step = 1'b1;
            default:      step = 1'b0;
         endcase
      end
      wrap   = step && (phase == LAST);
      reseed = load || wrap;
      g1_src = load ? g1_init : g1_seed;
      g2_src = load ? g2_init : g2_seed;
      t0_nxt = load ? t0 : t0_r;
      t1_nxt = load ? t1 : t1_r;
   end

   lfsr_step #(.N(N), .MASK(G1_MASK)) u_g1 (
      .clk   (clk),
      .rst   (rst),
      .ld    (reseed),
      .en    (step),
      .seed  (g1_src),
      .q_nxt (g1_nxt)
   );

   lfsr_step #(.N(N), .MASK(G2_MASK)) u_g2 (
      .clk   (clk),
      .rst   (rst),
      .ld    (reseed),
      .en    (step),
      .seed  (g2_src),
      .q_nxt (g2_nxt)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         g1_seed   <= '1;
         g2_seed   <= '1;
         t0_r      <= T0_PRN1;
         t1_r      <= T1_PRN1;
         phase     <= '0;
         chip_e    <= raw_chip('1, '1, T0_PRN1, T1_PRN1);
         chip_p    <= 1'b0;
         chip_l    <= 1'b0;
         epoch     <= 1'b0;
         state     <= SLEW_IDLE;
         rem       <= '0;
         slew_busy <= 1'b0;
      end else begin
         epoch  <= 1'b0;
         // chip_e follows the LFSR next-state so it lands on the same edge as the step.
         chip_e <= raw_chip(g1_nxt, g2_nxt, t0_nxt, t1_nxt);
         if (load) begin
            g1_seed   <= g1_init;
            g2_seed   <= g2_init;
            t0_r      <= t0;
            t1_r      <= t1;
            phase     <= '0;
            chip_p    <= 1'b0;
            chip_l    <= 1'b0;
            state     <= SLEW_IDLE;
            rem       <= '0;
            slew_busy <= 1'b0;
         end else begin
            if (step) begin
               chip_p <= chip_e;
               chip_l <= chip_p;
               if (wrap) begin
                  phase <= '0;
                  epoch <= 1'b1;
               end else begin
                  phase <= phase + 1'b1;
               end
            end
            case (state)
               SLEW_IDLE: begin
                  if (slew_req && (slew_cnt != '0)) begin
                     state     <= slew_dir ? SLEW_ADVANCE : SLEW_RETARD;
                     rem       <= slew_cnt;
                     slew_busy <= 1'b1;
                  end
               end
               SLEW_RETARD: begin
                  if (chip_en) begin
                     rem <= rem - 1'b1;
                     if (rem == PW'(1)) begin
                        state     <= SLEW_IDLE;
                        slew_busy <= 1'b0;
                     end
                  end
               end
               SLEW_ADVANCE: begin
                  if (!chip_en) begin
                     rem <= rem - 1'b1;
                     if (rem == PW'(1)) begin
                        state     <= SLEW_IDLE;
                        slew_busy <= 1'b0;
                     end
                  end
               end
               default: begin
                  state     <= SLEW_IDLE;
                  slew_busy <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_gold_code_gen.sv
// Scoreboard bench for gold_code_gen: GPS PRN 1 instance plus a 3-stage, 7-chip instance.
module tb_gold_code_gen;

   localparam int CL = 1023;
   localparam logic [15:0] MK1   = (16'd1 << 10) | (16'd1 << 3);
   localparam logic [15:0] MK2   = (16'd1 << 10) | (16'd1 << 9) | (16'd1 << 8) |
                                   (16'd1 << 6)  | (16'd1 << 3) | (16'd1 << 2);
   localparam logic [15:0] MK1_S = (16'd1 << 3) | (16'd1 << 2);
   localparam logic [15:0] MK2_S = (16'd1 << 3) | (16'd1 << 1);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, chip_en, load, slew_req, slew_dir;
   logic [9:0] g1_init, g2_init, slew_cnt, phase;
   logic [3:0] t0, t1;
   logic       slew_busy, chip_e, chip_p, chip_l, epoch;

   logic       chip_en_s, load_s, slew_req_s, slew_dir_s;
   logic [2:0] g1_init_s, g2_init_s, slew_cnt_s, phase_s;
   logic [3:0] t0_s, t1_s;
   logic       slew_busy_s, chip_e_s, chip_p_s, chip_l_s, epoch_s;

   gold_code_gen u_dut (
      .clk(clk), .rst(rst), .chip_en(chip_en), .load(load),
      .g1_init(g1_init), .g2_init(g2_init), .t0(t0), .t1(t1),
      .slew_req(slew_req), .slew_dir(slew_dir), .slew_cnt(slew_cnt),
      .slew_busy(slew_busy), .chip_e(chip_e), .chip_p(chip_p), .chip_l(chip_l),
      .epoch(epoch), .phase(phase)
   );

   gold_code_gen #(.N(3), .CODE_LEN(7), .G1_MASK(3'b110), .G2_MASK(3'b101)) u_small (
      .clk(clk), .rst(rst), .chip_en(chip_en_s), .load(load_s),
      .g1_init(g1_init_s), .g2_init(g2_init_s), .t0(t0_s), .t1(t1_s),
      .slew_req(slew_req_s), .slew_dir(slew_dir_s), .slew_cnt(slew_cnt_s),
      .slew_busy(slew_busy_s), .chip_e(chip_e_s), .chip_p(chip_p_s), .chip_l(chip_l_s),
      .epoch(epoch_s), .phase(phase_s)
   );

   // Model state is indexed by stage number: bit k is stage k, bit 0 unused.
   typedef struct {
      logic [15:0] g1, g2, s1, s2, mk1, mk2;
      int          n, codelen, t0, t1, phase;
      logic        ce, cp, cl;
   } mstate_t;

   typedef struct {
      logic ce, cp, cl, ep, busy;
      int   phase;
   } exp_t;

   exp_t    sb[$];
   int      n_vec = 0;
   int      n_err = 0;
   mstate_t m, r, ms;
   int      m_mode, m_rem;

   function automatic logic m_raw(mstate_t s);
      logic a, b;
      if (s.t0 == 0) return s.g1[s.n] ^ s.g2[s.n];
      a = (s.t0 <= s.n) ? s.g2[s.t0] : 1'b0;
      b = (s.t1 >= 1 && s.t1 <= s.n) ? s.g2[s.t1] : 1'b0;
      return s.g1[s.n] ^ a ^ b;
   endfunction

   function automatic mstate_t m_adv(mstate_t s);
      logic f1, f2;
      if (s.phase == s.codelen - 1) begin
         s.phase = 0;
         s.g1    = s.s1;
         s.g2    = s.s2;
      end else begin
         f1 = 1'b0;
         f2 = 1'b0;
         for (int k = 1; k <= s.n; k++) begin
            if (s.mk1[k]) f1 ^= s.g1[k];
            if (s.mk2[k]) f2 ^= s.g2[k];
         end
         for (int k = s.n; k >= 2; k--) begin
            s.g1[k] = s.g1[k-1];
            s.g2[k] = s.g2[k-1];
         end
         s.g1[1] = f1;
         s.g2[1] = f2;
         s.phase++;
      end
      s.cl = s.cp;
      s.cp = s.ce;
      s.ce = m_raw(s);
      return s;
   endfunction

   function automatic mstate_t m_reset(int n, int codelen, logic [15:0] mk1, logic [15:0] mk2);
      mstate_t s;
      s.g1 = '0;
      for (int k = 1; k <= n; k++) s.g1[k] = 1'b1;
      s.g2 = s.g1; s.s1 = s.g1; s.s2 = s.g1;
      s.mk1 = mk1; s.mk2 = mk2; s.n = n; s.codelen = codelen;
      s.t0 = 2; s.t1 = 6; s.phase = 0;
      s.cp = 1'b0; s.cl = 1'b0;
      s.ce = m_raw(s);
      return s;
   endfunction

   function automatic mstate_t m_load(mstate_t s, logic [9:0] i1, logic [9:0] i2, int a, int b);
      s.g1 = '0; s.g2 = '0;
      for (int k = 1; k <= s.n; k++) begin
         s.g1[k] = i1[k-1];
         s.g2[k] = i2[k-1];
      end
      s.s1 = s.g1; s.s2 = s.g2;
      s.t0 = a; s.t1 = b; s.phase = 0;
      s.cp = 1'b0; s.cl = 1'b0;
      s.ce = m_raw(s);
      return s;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic cyc(input logic en, input logic ld, input logic sreq, input logic sdir,
                      input int scnt, input logic [9:0] i1, input logic [9:0] i2,
                      input logic [3:0] a, input logic [3:0] b);
      exp_t e, x;
      logic stp;
      chip_en = en; load = ld; slew_req = sreq; slew_dir = sdir; slew_cnt = 10'(scnt);
      g1_init = i1; g2_init = i2; t0 = a; t1 = b;
      e.ep = 1'b0;
      if (ld) begin
         m = m_load(m, i1, i2, int'(a), int'(b));
         m_mode = 0; m_rem = 0;
      end else begin
         stp = (m_mode == 0 && en) || (m_mode == 2);
         if (stp) begin
            e.ep = (m.phase == m.codelen - 1);
            m = m_adv(m);
         end
         case (m_mode)
            0: if (sreq && scnt > 0) begin m_mode = sdir ? 2 : 1; m_rem = scnt; end
            1: if (en) begin m_rem--; if (m_rem == 0) m_mode = 0; end
            default: if (!en) begin m_rem--; if (m_rem == 0) m_mode = 0; end
         endcase
      end
      e.ce = m.ce; e.cp = m.cp; e.cl = m.cl; e.busy = (m_mode != 0); e.phase = m.phase;
      sb.push_back(e);
      @(posedge clk); #1;
      x = sb.pop_front();
      chk("chip_e", 32'(chip_e), 32'(x.ce));
      chk("chip_p", 32'(chip_p), 32'(x.cp));
      chk("chip_l", 32'(chip_l), 32'(x.cl));
      chk("epoch", 32'(epoch), 32'(x.ep));
      chk("slew_busy", 32'(slew_busy), 32'(x.busy));
      chk("phase", 32'(phase), 32'(x.phase));
      chip_en = 1'b0; load = 1'b0; slew_req = 1'b0;
   endtask

   task automatic chip();
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, '0, '0, '0, '0);
   endtask

   task automatic model_reset();
      m = m_reset(10, CL, MK1, MK2);
      ms = m_reset(3, 7, MK1_S, MK2_S);
      m_mode = 0; m_rem = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [9:0] prn1;
      logic [9:0] ld1, ld2;
      int         ep_cnt, busy_cnt, ep7_cnt;
      exp_t       e, x;

      prn1 = 10'b1100100000;
      rst = 1'b0; chip_en = 0; load = 0; slew_req = 0; slew_dir = 0; slew_cnt = '0;
      g1_init = '0; g2_init = '0; t0 = '0; t1 = '0;
      chip_en_s = 0; load_s = 0; slew_req_s = 0; slew_dir_s = 0; slew_cnt_s = '0;
      g1_init_s = '0; g2_init_s = '0; t0_s = '0; t1_s = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      chk("rst_chip_e", 32'(chip_e), 32'd1);
      chk("rst_chip_p", 32'(chip_p), 32'd0);
      chk("rst_chip_l", 32'(chip_l), 32'd0);
      chk("rst_epoch", 32'(epoch), 32'd0);
      chk("rst_busy", 32'(slew_busy), 32'd0);
      chk("rst_phase", 32'(phase), 32'd0);

      // PRN 1 first ten chips, one full epoch, then the same ten again.
      ep_cnt = 0;
      for (int i = 0; i < CL; i++) begin
         if (i < 10) chk("prn1_head", 32'(chip_e), 32'(prn1[9-i]));
         chip();
         if (epoch) ep_cnt++;
      end
      chk("epoch_count", 32'(ep_cnt), 32'd1);
      chk("wrap_phase", 32'(phase), 32'd0);
      for (int i = 0; i < 10; i++) begin
         chk("prn1_repeat", 32'(chip_e), 32'(prn1[9-i]));
         chip();
      end

      // Retard by 5 over 20 chip strobes; a request while busy must be ignored.
      r = m;
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 5, '0, '0, '0, '0);
      busy_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (slew_busy) busy_cnt++;
         cyc(1'b1, 1'b0, (i == 1), 1'b1, 7, '0, '0, '0, '0);
         r = m_adv(r);
      end
      chk("retard_busy_chips", 32'(busy_cnt), 32'd5);
      chk("retard_lag", 32'(phase), 32'((r.phase + CL - 5) % CL));
      chk("retard_chip", 32'(chip_e), 32'(m.ce));

      // Advance by 3 with chip_en every 4th clock, straddling the epoch wrap.
      for (int k = 0; k < 2000 && m.phase != 1020; k++) chip();
      chk("reach_1020", 32'(phase), 32'd1020);
      r = m;
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 3, '0, '0, '0, '0);
      ep_cnt = 0;
      for (int i = 0; i < 16; i++) begin
         cyc((i % 4 == 3), 1'b0, 1'b0, 1'b0, 0, '0, '0, '0, '0);
         if (i % 4 == 3) r = m_adv(r);
         if (epoch) ep_cnt++;
      end
      chk("advance_lead", 32'(phase), 32'((r.phase + 3) % CL));
      chk("advance_epoch", 32'(ep_cnt), 32'd1);
      chk("advance_idle", 32'(slew_busy), 32'd0);

      // Load with G2-init mode at phase 500 mid-advance, colliding with chip_en and slew_req.
      for (int k = 0; k < 2000 && m.phase != 500; k++) chip();
      chk("reach_500", 32'(phase), 32'd500);
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 300, '0, '0, '0, '0);
      chk("adv_busy", 32'(slew_busy), 32'd1);
      ld1 = 10'h2A5;
      ld2 = 10'h13C;
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 5, ld1, ld2, 4'd0, 4'd5);
      chk("load_busy", 32'(slew_busy), 32'd0);
      chk("load_phase", 32'(phase), 32'd0);
      chk("load_chip_e", 32'(chip_e), 32'(ld1[9] ^ ld2[9]));
      chk("load_epoch", 32'(epoch), 32'd0);
      repeat (12) chip();

      // Reset in the middle of a retard: nothing of the slew may survive.
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 5, '0, '0, '0, '0);
      chip();
      rst = 1'b0;
      #2;
      chk("async_busy", 32'(slew_busy), 32'd0);
      chk("async_phase", 32'(phase), 32'd0);
      chk("async_chip_e", 32'(chip_e), 32'd1);
      model_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      chip();
      chk("first_step", 32'(phase), 32'd1);

      // Short code: epoch every 7 strobes.
      ep7_cnt = 0;
      for (int i = 0; i < 21; i++) begin
         e.ep = (ms.phase == 6);
         ms = m_adv(ms);
         e.ce = ms.ce; e.cp = ms.cp; e.cl = ms.cl; e.busy = 1'b0; e.phase = ms.phase;
         sb.push_back(e);
         chip_en_s = 1'b1;
         @(posedge clk); #1;
         x = sb.pop_front();
         chk("s_epoch", 32'(epoch_s), 32'(x.ep));
         chk("s_phase", 32'(phase_s), 32'(x.phase));
         chk("s_chip_e", 32'(chip_e_s), 32'(x.ce));
         chk("s_chip_p", 32'(chip_p_s), 32'(x.cp));
         chk("s_chip_l", 32'(chip_l_s), 32'(x.cl));
         chk("s_busy", 32'(slew_busy_s), 32'(x.busy));
         if (epoch_s) ep7_cnt++;
      end
      chip_en_s = 1'b0;
      chk("s_epoch_count", 32'(ep7_cnt), 32'd3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
